// File: rtl/xor_parity_checker_if.sv
// Bit-stream in / frame-out handshake bundle for the XOR parity checker.
// master = environment side (drives stream and consumer ready); slave = checker side.
interface xor_parity_checker_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_bit;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_perr;
  logic              m_ready;

  modport master (
    output s_valid, s_bit, m_ready,
    input  s_ready, m_valid, m_data, m_perr
  );

  modport slave (
    input  s_valid, s_bit, m_ready,
    output s_ready, m_valid, m_data, m_perr
  );
endinterface

// File: rtl/xor_parity_checker.sv
// Serial XOR parity checker: collects DATA_W bits LSB first plus a parity bit.
// Presents the word with a parity-error flag; XPC_ERR_COUNT_EN adds a saturating error count.
module xor_parity_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xor_parity_checker_if.slave  bus
`ifdef XPC_ERR_COUNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic              ODD_BIT  = (ODD != 0);

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_PARITY = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic              acc_r, acc_s;
  logic [DATA_W-1:0] m_data_r, m_data_s;
  logic              m_valid_r, m_valid_s;
  logic              m_perr_r, m_perr_s;
  logic              accept_s;
`ifdef XPC_ERR_COUNT_EN
  logic [15:0]       err_cnt_r, err_cnt_s;
`endif

  // Mismatch when the running XOR, the received parity bit and the parity sense disagree.
  function automatic logic parity_err_f(input logic acc, input logic par, input logic odd);
    return acc ^ par ^ odd;
  endfunction

  // Next-state and datapath decode; every register holds unless its state says otherwise.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    acc_s     = acc_r;
    m_data_s  = m_data_r;
    m_valid_s = m_valid_r;
    m_perr_s  = m_perr_r;
`ifdef XPC_ERR_COUNT_EN
    err_cnt_s = err_cnt_r;
`endif
    accept_s  = bus.s_valid && (state_r != ST_HOLD);

    case (state_r)
      ST_RECV: begin
        if (accept_s) begin
          m_data_s[bit_cnt_r] = bus.s_bit;
          acc_s               = acc_r ^ bus.s_bit;
          bit_cnt_s           = bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == LAST_IDX) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_RECV;
          end
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_PARITY: begin
        if (accept_s) begin
          m_perr_s  = parity_err_f(acc_r, bus.s_bit, ODD_BIT);
          m_valid_s = 1'b1;
          state_s   = ST_HOLD;
`ifdef XPC_ERR_COUNT_EN
          if (m_perr_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_s = err_cnt_r + 16'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
`endif
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_HOLD: begin
        if (bus.m_ready) begin
          m_valid_s = 1'b0;
          acc_s     = 1'b0;
          bit_cnt_s = '0;
          state_s   = ST_RECV;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s   = ST_RECV;
        bit_cnt_s = '0;
        acc_s     = 1'b0;
        m_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_RECV;
      bit_cnt_r <= '0;
      acc_r     <= 1'b0;
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
      m_perr_r  <= 1'b0;
`ifdef XPC_ERR_COUNT_EN
      err_cnt_r <= 16'd0;
`endif
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      acc_r     <= acc_s;
      m_data_r  <= m_data_s;
      m_valid_r <= m_valid_s;
      m_perr_r  <= m_perr_s;
`ifdef XPC_ERR_COUNT_EN
      err_cnt_r <= err_cnt_s;
`endif
    end
  end

  // Ready is a decode of the state register only, so m_ready never reaches s_ready.
  assign bus.s_ready = (state_r != ST_HOLD);
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_perr  = m_perr_r;
`ifdef XPC_ERR_COUNT_EN
  assign err_cnt     = err_cnt_r;
`endif

endmodule

// File: tb/tb_xor_parity_checker.sv
// Directed bench: an even-parity and an odd-parity checker share one stimulus stream.
// Both are checked against hand-computed frame results; counter checks build with XPC_ERR_COUNT_EN.
module tb_xor_parity_checker;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  xor_parity_checker_if #(.DATA_W(8)) ifa ();
  xor_parity_checker_if #(.DATA_W(8)) ifb ();

  assign ifb.s_valid = ifa.s_valid;
  assign ifb.s_bit   = ifa.s_bit;
  assign ifb.m_ready = ifa.m_ready;

`ifdef XPC_ERR_COUNT_EN
  logic [15:0] err_cnt0, err_cnt1;
  xor_parity_checker #(.DATA_W(8), .ODD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa), .err_cnt(err_cnt0));
  xor_parity_checker #(.DATA_W(8), .ODD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb), .err_cnt(err_cnt1));
`else
  xor_parity_checker #(.DATA_W(8), .ODD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
  xor_parity_checker #(.DATA_W(8), .ODD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed frame handshakes on the even-parity checker.
  always @(posedge clk) begin
    if (rst_n && ifa.m_valid && ifa.m_ready) hs_cnt <= hs_cnt + 1;
  end

  // Sends 8 data bits LSB first then the parity bit; returns on the negedge after the parity accept.
  task automatic send_frame(input logic [7:0] d, input logic p);
    logic [8:0] v;
    v = {p, d};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ifa.s_valid = 1'b1;
      ifa.s_bit   = v[i];
    end
    @(negedge clk);
    ifa.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifa.s_valid = 1'b0; ifa.s_bit = 1'b0; ifa.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0h exp 0", ifa.m_valid); end
    checks++; if (ifa.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL reset_m_perr got %0h exp 0", ifa.m_perr); end
    checks++; if (ifa.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0h exp 1", ifa.s_ready); end
    checks++; if (ifb.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready_odd got %0h exp 1", ifb.s_ready); end
`ifdef XPC_ERR_COUNT_EN
    checks++; if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %h exp 0000", err_cnt0); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_clean_even();
    ifa.m_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    checks++; if (ifa.m_valid !== 1'b1) begin errors++; $display("FAIL clean_m_valid got %0h exp 1", ifa.m_valid); end
    checks++; if (ifa.m_data !== 8'hA5) begin errors++; $display("FAIL clean_m_data got %h exp a5", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL clean_m_perr got %0h exp 0", ifa.m_perr); end
    checks++; if (ifb.m_perr !== 1'b1) begin errors++; $display("FAIL clean_m_perr_odd got %0h exp 1", ifb.m_perr); end
    checks++; if (ifa.s_ready !== 1'b0) begin errors++; $display("FAIL clean_hold_s_ready got %0h exp 0", ifa.s_ready); end
    @(negedge clk);
    checks++; if (ifa.s_ready !== 1'b1) begin errors++; $display("FAIL clean_next_s_ready got %0h exp 1", ifa.s_ready); end
    checks++; if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL clean_next_m_valid got %0h exp 0", ifa.m_valid); end
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1);
    checks++; if (ifa.m_data !== 8'hA5) begin errors++; $display("FAIL perr_m_data got %h exp a5", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b1) begin errors++; $display("FAIL perr_m_perr got %0h exp 1", ifa.m_perr); end
    checks++; if (ifb.m_perr !== 1'b0) begin errors++; $display("FAIL perr_m_perr_odd got %0h exp 0", ifb.m_perr); end
`ifdef XPC_ERR_COUNT_EN
    checks++; if (err_cnt0 !== 16'd1) begin errors++; $display("FAIL perr_err_cnt got %h exp 0001", err_cnt0); end
`endif
    @(negedge clk);
  endtask

  task automatic test_odd();
    send_frame(8'h07, 1'b0);
    checks++; if (ifb.m_perr !== 1'b0) begin errors++; $display("FAIL odd_p0_perr got %0h exp 0", ifb.m_perr); end
    checks++; if (ifa.m_perr !== 1'b1) begin errors++; $display("FAIL odd_p0_perr_even got %0h exp 1", ifa.m_perr); end
    checks++; if (ifb.m_data !== 8'h07) begin errors++; $display("FAIL odd_p0_data got %h exp 07", ifb.m_data); end
    send_frame(8'h07, 1'b1);
    checks++; if (ifb.m_perr !== 1'b1) begin errors++; $display("FAIL odd_p1_perr got %0h exp 1", ifb.m_perr); end
    checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL odd_p1_perr_even got %0h exp 0", ifa.m_perr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs0;
    ifa.m_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      ifa.s_valid = 1'b1;
      ifa.s_bit   = i[0];
      @(negedge clk);
      checks++; if (ifa.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d] got %0h exp 0", i, ifa.s_ready); end
      checks++; if (ifa.m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid[%0d] got %0h exp 1", i, ifa.m_valid); end
      checks++; if (ifa.m_data !== 8'h5A) begin errors++; $display("FAIL bp_m_data[%0d] got %h exp 5a", i, ifa.m_data); end
      checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL bp_m_perr[%0d] got %0h exp 0", i, ifa.m_perr); end
    end
    ifa.s_valid = 1'b0;
    checks++; if (hs_cnt !== hs0) begin errors++; $display("FAIL bp_frame_cnt got %0d exp %0d", hs_cnt, hs0); end
    ifa.m_ready = 1'b1;
    @(negedge clk);
    checks++; if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_m_valid got %0h exp 0", ifa.m_valid); end
    checks++; if (ifa.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_ready got %0h exp 1", ifa.s_ready); end
    checks++; if (hs_cnt !== hs0 + 1) begin errors++; $display("FAIL bp_release_frame_cnt got %0d exp %0d", hs_cnt, hs0 + 1); end
  endtask

  task automatic test_reset_mid_frame();
    ifa.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifa.s_valid = 1'b1;
      ifa.s_bit   = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ifa.m_data !== 8'h00) begin errors++; $display("FAIL rstmid_m_data got %h exp 00", ifa.m_data); end
    checks++; if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got %0h exp 0", ifa.m_valid); end
    checks++; if (ifa.s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready got %0h exp 1", ifa.s_ready); end
    rst_n = 1'b1;
    ifa.s_valid = 1'b0;
    send_frame(8'h3C, 1'b0);
    checks++; if (ifa.m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_frame_valid got %0h exp 1", ifa.m_valid); end
    checks++; if (ifa.m_data !== 8'h3C) begin errors++; $display("FAIL rstmid_frame_data got %h exp 3c", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL rstmid_frame_perr got %0h exp 0", ifa.m_perr); end
    checks++; if (ifb.m_perr !== 1'b1) begin errors++; $display("FAIL rstmid_frame_perr_odd got %0h exp 1", ifb.m_perr); end
`ifdef XPC_ERR_COUNT_EN
    checks++; if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL rstmid_err_cnt got %h exp 0000", err_cnt0); end
    checks++; if (err_cnt1 !== 16'd1) begin errors++; $display("FAIL rstmid_err_cnt_odd got %h exp 0001", err_cnt1); end
`endif
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_cnt;
    send_frame(8'hFF, 1'b1);
    checks++; if (ifa.m_data !== 8'hFF) begin errors++; $display("FAIL b2b_a_data got %h exp ff", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b1) begin errors++; $display("FAIL b2b_a_perr got %0h exp 1", ifa.m_perr); end
    send_frame(8'h81, 1'b0);
    checks++; if (ifa.m_data !== 8'h81) begin errors++; $display("FAIL b2b_b_data got %h exp 81", ifa.m_data); end
    checks++; if (ifa.m_perr !== 1'b0) begin errors++; $display("FAIL b2b_b_perr got %0h exp 0", ifa.m_perr); end
    checks++; if (ifb.m_perr !== 1'b1) begin errors++; $display("FAIL b2b_b_perr_odd got %0h exp 1", ifb.m_perr); end
    @(negedge clk);
    checks++; if (hs_cnt !== hs0 + 3) begin errors++; $display("FAIL b2b_frame_cnt got %0d exp %0d", hs_cnt, hs0 + 3); end
  endtask

`ifdef XPC_ERR_COUNT_EN
  task automatic test_err_saturation();
    @(negedge clk);
    force dut0.err_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut0.err_cnt_r;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hA5, 1'b1);
      checks++; if (err_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL sat_err_cnt[%0d] got %h exp ffff", i, err_cnt0); end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    ifa.s_valid = 1'b0;
    ifa.s_bit   = 1'b0;
    ifa.m_ready = 1'b0;
    rst_n       = 1'b0;
    test_reset();
    test_clean_even();
    test_parity_error();
    test_odd();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef XPC_ERR_COUNT_EN
    test_err_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
